// File: rtl/conv9_pkg.sv
// Shared sizes, row/kernel types and fill-state encoding for the conv9 kernel loader.
package conv9_pkg;

    localparam int WEIGHT_W   = 18;
    localparam int KERNEL_DIM = 9;
    localparam int ROW_IDX_W  = 4;

    typedef logic [KERNEL_DIM-1:0][WEIGHT_W-1:0]                  weight_row_t;
    typedef logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0]  kernel_t;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_e;

endpackage

// File: rtl/conv9_row_bank.sv
// KERNEL_DIM x row register array: single-row indexed write, or whole-bank load.
// The shadow bank uses the row port, the active bank uses the bank port.
module conv9_row_bank
    import conv9_pkg::*;
#(
    parameter int WEIGHT_W   = conv9_pkg::WEIGHT_W,
    parameter int KERNEL_DIM = conv9_pkg::KERNEL_DIM,
    parameter int IDX_W      = conv9_pkg::ROW_IDX_W
) (
    input  logic                                               clk_in,
    input  logic                                               rst_in,
    input  logic                                               i_row_we,
    input  logic [IDX_W-1:0]                                   i_row_idx,
    input  logic [KERNEL_DIM-1:0][WEIGHT_W-1:0]                i_row_data,
    input  logic                                               i_bank_we,
    input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0] i_bank_data,
    output logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0] o_bank
);

    logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0] r_mem;

    // Bank load has priority; the two ports are never used on the same instance.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mem <= '0;
        end else if (i_bank_we) begin
            r_mem <= i_bank_data;
        end else if (i_row_we) begin
            for (int r = 0; r < KERNEL_DIM; r++) begin
                if (i_row_idx == IDX_W'(r)) r_mem[r] <= i_row_data;
            end
        end
    end

    assign o_bank = r_mem;

endmodule

// File: rtl/conv9_kernel_loader.sv
// Double-buffered 9x9 weight kernel loader: rows fill a shadow bank, full kernels move to the active bank.
// Define CONV9_ROW_CHECK_EN to enforce in-order row numbering (out-of-order rows restart the fill).
module conv9_kernel_loader
    import conv9_pkg::*;
#(
    parameter int WEIGHT_W   = conv9_pkg::WEIGHT_W,
    parameter int KERNEL_DIM = conv9_pkg::KERNEL_DIM
) (
    input  logic                                               clk_in,
    input  logic                                               rst_in,
    input  logic                                               data_valid_in,
    input  logic [KERNEL_DIM-1:0][WEIGHT_W-1:0]                conv_9_weight_row,
    input  logic [ROW_IDX_W-1:0]                               row_num,
    input  logic                                               kernel_consume_in,
    output logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0] kernel_out,
    output logic                                               kernel_valid_out,
    output logic                                               load_error_out,
    output logic                                               overflow_out
);

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(KERNEL_DIM - 1);

    fill_state_e          r_state, w_state_nxt;
    logic [ROW_IDX_W-1:0] r_cnt, w_cnt_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic                 w_row_we;
    logic                 w_xfer;
    logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0] w_shadow;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= FILLING;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_err_nxt   = 1'b0;
        w_ovf_nxt   = r_ovf;
        w_row_we    = 1'b0;
        w_xfer      = 1'b0;

        // A consume in the transfer cycle hands over straight to the new kernel.
        if (r_state == FULL && (!r_valid || kernel_consume_in)) begin
            w_xfer      = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = FILLING;
        end else if (r_valid && kernel_consume_in) begin
            w_valid_nxt = 1'b0;
        end

        if (data_valid_in) begin
            if (row_num > LAST_ROW) w_err_nxt = 1'b1;
            if (r_state == FULL) begin
                w_ovf_nxt = 1'b1;
            end else if (row_num <= LAST_ROW) begin
`ifdef CONV9_ROW_CHECK_EN
                if (row_num == r_cnt) begin
                    w_row_we = 1'b1;
                    if (row_num == LAST_ROW) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    // Restart the fill; a stray row 0 doubles as the new first row.
                    w_err_nxt = 1'b1;
                    w_row_we  = (row_num == '0);
                    w_cnt_nxt = (row_num == '0) ? ROW_IDX_W'(1) : '0;
                end
`else
                w_row_we = 1'b1;
                if (row_num == LAST_ROW) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = FULL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
        end
    end

    conv9_row_bank #(
        .WEIGHT_W   (WEIGHT_W),
        .KERNEL_DIM (KERNEL_DIM),
        .IDX_W      (ROW_IDX_W)
    ) u_shadow (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_row_we    (w_row_we),
        .i_row_idx   (row_num),
        .i_row_data  (conv_9_weight_row),
        .i_bank_we   (1'b0),
        .i_bank_data ('0),
        .o_bank      (w_shadow)
    );

    conv9_row_bank #(
        .WEIGHT_W   (WEIGHT_W),
        .KERNEL_DIM (KERNEL_DIM),
        .IDX_W      (ROW_IDX_W)
    ) u_active (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_row_we    (1'b0),
        .i_row_idx   ('0),
        .i_row_data  ('0),
        .i_bank_we   (w_xfer),
        .i_bank_data (w_shadow),
        .o_bank      (kernel_out)
    );

    assign kernel_valid_out = r_valid;
    assign load_error_out   = r_err;
    assign overflow_out     = r_ovf;

endmodule

// File: tb/tb_conv9_kernel_loader.sv
// Self-checking bench for conv9_kernel_loader: vector table, kernel scoreboard, corner-case sequences.
`timescale 1ns/1ps
module tb_conv9_kernel_loader;

    localparam int W = 18;
    localparam int K = 9;
`ifdef CONV9_ROW_CHECK_EN
    localparam logic ROW_CHK = 1'b1;
`else
    localparam logic ROW_CHK = 1'b0;
`endif

    typedef logic [K-1:0][W-1:0]        row_t;
    typedef logic [K-1:0][K-1:0][W-1:0] kern_t;
    typedef struct {
        logic       dv;
        logic [3:0] rn;
        int         kid;
        logic       cons;
        logic       push;
        logic       exp_err;
        logic       exp_ovf;
        logic       exp_val;
    } vec_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       data_valid_in = 1'b0;
    logic       kernel_consume_in = 1'b0;
    row_t       conv_9_weight_row = '0;
    logic [3:0] row_num = '0;
    kern_t      kernel_out;
    logic       kernel_valid_out, load_error_out, overflow_out;

    int    checks = 0;
    int    failures = 0;
    kern_t sb_q[$];
    vec_t  tbl[$];
    logic  mon_prev_v = 1'b0;
    kern_t mon_prev_k = '0;

    conv9_kernel_loader #(.WEIGHT_W(W), .KERNEL_DIM(K)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .data_valid_in     (data_valid_in),
        .conv_9_weight_row (conv_9_weight_row),
        .row_num           (row_num),
        .kernel_consume_in (kernel_consume_in),
        .kernel_out        (kernel_out),
        .kernel_valid_out  (kernel_valid_out),
        .load_error_out    (load_error_out),
        .overflow_out      (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    // Weights row*16+col offset by kernel id, with the most negative value sprinkled in.
    function automatic row_t mk_row(input int kid, input int r);
        row_t x;
        for (int c = 0; c < K; c++) begin
            int v;
            v = kid * 256 + r * 16 + c;
            if ((r + c + kid) % 4 == 0) v = -131072;
            x[c] = W'(v);
        end
        return x;
    endfunction

    function automatic kern_t mk_kern(input int kid);
        kern_t k;
        for (int r = 0; r < K; r++) k[r] = mk_row(kid, r);
        return k;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_k(input string name, input kern_t act, input kern_t exp);
        int fr, fc;
        checks++;
        if (act !== exp) begin
            failures++;
            fr = -1; fc = -1;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    if (fr < 0 && act[r][c] !== exp[r][c]) begin fr = r; fc = c; end
            $display("FAIL %s: kernel[%0d][%0d] got %0h expected %0h", name, fr, fc,
                     act[fr][fc], exp[fr][fc]);
        end
    endtask

    // Scoreboard: a new kernel appears when valid rises or the kernel changes while valid.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            mon_prev_v = 1'b0;
            mon_prev_k = '0;
        end else begin
            if (kernel_valid_out && (!mon_prev_v || kernel_out !== mon_prev_k)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: kernel appeared with no expected entry");
                end else begin
                    chk_k("sb_kernel", kernel_out, sb_q.pop_front());
                end
            end
            mon_prev_v = kernel_valid_out;
            mon_prev_k = kernel_out;
        end
    end

    task automatic cyc(input logic dv, input logic [3:0] rn, input int kid, input logic cons);
        data_valid_in     = dv;
        row_num           = rn;
        conv_9_weight_row = mk_row(kid, int'(rn));
        kernel_consume_in = cons;
        @(negedge clk_in);
        data_valid_in     = 1'b0;
        kernel_consume_in = 1'b0;
    endtask

    task automatic send_kernel(input int kid, input logic push);
        if (push) sb_q.push_back(mk_kern(kid));
        for (int r = 0; r < K; r++) cyc(1'b1, 4'(r), kid, 1'b0);
    endtask

    task automatic add(input logic dv, input logic [3:0] rn, input int kid, input logic cons,
                       input logic push, input logic e, input logic o, input logic v);
        tbl.push_back('{dv, rn, kid, cons, push, e, o, v});
    endtask

    initial begin
        // Table: kernel 0 in order, stray row 12, kernel 1 with row 12 mid-fill, consume cases.
        for (int r = 0; r < K; r++) add(1'b1, 4'(r), 0, 1'b0, r == K-1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'd0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 4'd12, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 4'd0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) add(1'b1, 4'(r), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 4'd12, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int r = 4; r < K; r++) add(1'b1, 4'(r), 1, 1'b0, r == K-1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 4'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 4'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 4'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        #1 rst_in = 1'b0;
        #1;
        chk("rst_valid", kernel_valid_out, 1'b0);
        chk("rst_err",   load_error_out,   1'b0);
        chk("rst_ovf",   overflow_out,     1'b0);
        chk_k("rst_kernel", kernel_out, '0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        foreach (tbl[i]) begin
            if (tbl[i].push) sb_q.push_back(mk_kern(tbl[i].kid));
            cyc(tbl[i].dv, tbl[i].rn, tbl[i].kid, tbl[i].cons);
            chk($sformatf("vec%0d_err", i), load_error_out,   tbl[i].exp_err);
            chk($sformatf("vec%0d_ovf", i), overflow_out,     tbl[i].exp_ovf);
            chk($sformatf("vec%0d_val", i), kernel_valid_out, tbl[i].exp_val);
        end
        chk_k("consume_retains", kernel_out, mk_kern(1));

        // Overflow: A active, B parked in shadow, C row 0 dropped; consume swaps in B.
        send_kernel(2, 1'b1);
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("ovf_a_valid", kernel_valid_out, 1'b1);
        send_kernel(3, 1'b1);
        cyc(1'b1, 4'd0, 4, 1'b0);
        chk("ovf_set", overflow_out, 1'b1);
        chk("ovf_no_err", load_error_out, 1'b0);
        chk_k("ovf_a_held", kernel_out, mk_kern(2));
        cyc(1'b0, 4'd0, 0, 1'b1);
        chk("swap_valid", kernel_valid_out, 1'b1);
        chk_k("swap_kernel_b", kernel_out, mk_kern(3));
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("ovf_sticky", overflow_out, 1'b1);
        cyc(1'b0, 4'd0, 0, 1'b1);
        chk("b_consumed", kernel_valid_out, 1'b0);

        // Out-of-order rows 0,1,3 then a clean load.
        cyc(1'b1, 4'd0, 5, 1'b0);
        cyc(1'b1, 4'd1, 5, 1'b0);
        chk("seq_row1_err", load_error_out, 1'b0);
        cyc(1'b1, 4'd3, 5, 1'b0);
        chk("seq_row3_err", load_error_out, ROW_CHK);
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("seq_err_pulse", load_error_out, 1'b0);
        send_kernel(6, 1'b1);
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("seq_clean_valid", kernel_valid_out, 1'b1);
        cyc(1'b0, 4'd0, 0, 1'b1);
        chk("seq_consumed", kernel_valid_out, 1'b0);
`ifdef CONV9_ROW_CHECK_EN
        // A stray row 0 restarts the fill and is kept as the new row 0.
        cyc(1'b1, 4'd0, 7, 1'b0);
        cyc(1'b1, 4'd1, 7, 1'b0);
        cyc(1'b1, 4'd0, 7, 1'b0);
        chk("restart_row0_err", load_error_out, 1'b1);
        sb_q.push_back(mk_kern(7));
        for (int r = 1; r < K; r++) cyc(1'b1, 4'(r), 7, 1'b0);
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("restart_valid", kernel_valid_out, 1'b1);
        cyc(1'b0, 4'd0, 0, 1'b1);
`endif

        // Reset mid-fill clears everything, including the sticky overflow flag.
        for (int r = 0; r < 6; r++) cyc(1'b1, 4'(r), 8, 1'b0);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_valid", kernel_valid_out, 1'b0);
        chk("arst_err",   load_error_out,   1'b0);
        chk("arst_ovf",   overflow_out,     1'b0);
        chk_k("arst_kernel", kernel_out, '0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        send_kernel(9, 1'b1);
        chk("post_rst_latency", kernel_valid_out, 1'b0);
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("post_rst_valid", kernel_valid_out, 1'b1);
        chk("post_rst_ovf", overflow_out, 1'b0);
        cyc(1'b0, 4'd0, 0, 1'b0);
        chk("sb_drained", sb_q.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv9_kernel_loader.md
CONV9_KERNEL_LOADER -- requirements
Module: conv9_kernel_loader

Interface
REQ-001 Parameter WEIGHT_W, default 18, signed weight width in bits.
REQ-002 Parameter KERNEL_DIM, default 9, weights per row and rows per kernel.
REQ-003 clk_in  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_in  input  1  reset, asynchronous assert, active-low (0 = reset), released synchronously to clk_in.
REQ-005 data_valid_in  input  1  a weight row is present this cycle.
REQ-006 conv_9_weight_row  input  [KERNEL_DIM-1:0][WEIGHT_W-1:0] signed  one kernel row, element 0 = leftmost tap.
REQ-007 row_num  input  4  index of the presented row, 0..KERNEL_DIM-1.
REQ-008 kernel_consume_in  input  1  the convolution engine has latched the active kernel and releases it.
REQ-009 kernel_out  output  [KERNEL_DIM-1:0][KERNEL_DIM-1:0][WEIGHT_W-1:0] signed  active kernel, [row][col].
REQ-010 kernel_valid_out  output  1  kernel_out holds a complete, unconsumed kernel.
REQ-011 load_error_out  output  1  one-cycle pulse on a rejected row.
REQ-012 overflow_out  output  1  sticky flag: a row arrived while the shadow bank was full.

Function
REQ-013 The block SHALL hold two banks: a shadow bank being filled and an active bank driving kernel_out.
REQ-014 An expected-row counter SHALL start at 0; a row is accepted when data_valid_in=1, shadow not full, and row_num equals the counter.
REQ-015 An accepted row SHALL be written to shadow[row_num] unmodified, and the counter SHALL increment by 1.
REQ-016 Acceptance of row KERNEL_DIM-1 SHALL set shadow_full and return the counter to 0 (wrap).
REQ-017 Fill state machine: FILLING (counter 0..8) -> FULL on row 8 accepted -> FILLING on transfer to active.
REQ-018 Transfer SHALL occur in the cycle after shadow_full is set (or any later cycle) when kernel_valid_out=0 or kernel_consume_in=1.
REQ-019 Latency: row 8 accepted at edge N with the active bank free -> kernel_out updated and kernel_valid_out=1 after edge N+1.
REQ-020 Consume and transfer in the same cycle SHALL load the new kernel and hold kernel_valid_out at 1 without a gap.
REQ-021 Consume with no pending transfer SHALL clear kernel_valid_out on the next edge; kernel_out SHALL retain its value.
REQ-022 kernel_consume_in while kernel_valid_out=0 SHALL be ignored.
REQ-023 data_valid_in=1 while shadow_full=1 SHALL drop the row, set overflow_out, and leave the shadow bank unchanged.
REQ-024 row_num greater than KERNEL_DIM-1 SHALL always be dropped with a load_error_out pulse.
REQ-025 No arithmetic SHALL be applied to weights; sign and width are preserved bit-exactly.

Reset
REQ-026 While rst_in=0: kernel_out=0, kernel_valid_out=0, load_error_out=0, overflow_out=0, counter=0, shadow_full=0, state FILLING.
REQ-027 Reset mid-fill or mid-transfer SHALL discard all partial rows; the first row after release is expected to be row 0.
REQ-028 overflow_out SHALL be cleared only by reset.

Configuration
REQ-029 Macro CONV9_ROW_CHECK_EN defined: a row with row_num not equal to the counter SHALL pulse load_error_out, discard the partial shadow fill, and reset the counter to 0; if that row has row_num=0, it SHALL be accepted as row 0.
REQ-030 Macro CONV9_ROW_CHECK_EN undefined: any row with row_num<=8 SHALL be written to shadow[row_num], shadow_full SHALL set on row_num=8, and load_error_out SHALL pulse only per REQ-024.

Structure
REQ-031 Package conv9_pkg SHALL hold WEIGHT_W, KERNEL_DIM, typedef weight_row_t and typedef kernel_t.
REQ-032 Sub-module conv9_row_bank (a KERNEL_DIM-row register array with row write enable and row index) SHALL implement both banks.

Verification
REQ-033 Rows 0..8 on consecutive cycles, weights row*16+col, including -131072 entries -> kernel_valid_out=1 one cycle after row 8; kernel_out[r][c] matches bit-exactly.
REQ-034 Kernel A valid and not consumed, kernel B rows 0..8 sent, then row 0 of C sent -> overflow_out=1; consume pulse -> kernel_out=B the next cycle with valid held at 1.
REQ-035 With CONV9_ROW_CHECK_EN defined, rows 0,1,3 sent -> load_error_out pulses on row 3; a following 0..8 sequence loads cleanly.
REQ-036 Row with row_num=12 -> load_error_out pulse, counter and shadow unchanged.
REQ-037 rst_in driven low after row 5 -> all outputs 0 asynchronously; after release, rows 0..8 yield a valid kernel.
